// File: rtl/data_path.sv
// Single-cycle MIPS-style datapath: PC sequencing, 32x32 register file,
// sign extension and an 8-function ALU driven by externally decoded controls.
module data_path (
  input  logic        clk,
  input  logic        rst,
  input  logic        Jump,
  input  logic        Branch,
  input  logic [2:0]  ALU_Control,
  input  logic        ALUSrc_B,
  input  logic        RegWrite,
  input  logic        RegDst,
  input  logic        MemtoReg,
  input  logic [25:0] inst_field,
  input  logic [31:0] Data_in,
  output logic [31:0] PC_out,
  output logic [31:0] ALU_out,
  output logic [31:0] Data_out
);

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_NOR = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;

  alu_op_t     alu_op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  wr_addr;
  logic [15:0] imm;
  logic [25:0] target;

  logic [31:0] regs [32];
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] ext;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic [31:0] wb_data;
  logic        zero;

  logic [31:0] pc_reg;
  logic [31:0] pc4;
  logic [31:0] pc_branch;
  logic [31:0] pc_jump;
  logic [31:0] pc_next;

  // Instruction field extraction
  assign rs     = inst_field[25:21];
  assign rt     = inst_field[20:16];
  assign rd     = inst_field[15:11];
  assign imm    = inst_field[15:0];
  assign target = inst_field[25:0];
  assign alu_op = alu_op_t'(ALU_Control);

  // Register 0 is hardwired; the read mux hides whatever its storage holds.
  assign rs_data = (rs == 5'd0) ? '0 : regs[rs];
  assign rt_data = (rt == 5'd0) ? '0 : regs[rt];

  assign ext  = {{16{imm[15]}}, imm};
  assign op_a = rs_data;
  assign op_b = ALUSrc_B ? ext : rt_data;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_ADD: alu_res = op_a + op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_NOR: alu_res = ~(op_a | op_b);
      ALU_SRL: alu_res = op_a >> op_b[4:0];
      ALU_SUB: alu_res = op_a - op_b;
      ALU_SLT: alu_res = {31'd0, ($signed(op_a) < $signed(op_b))};
      default: alu_res = '0;
    endcase
  end

  assign zero = (alu_res == '0);

  // Write-back selection
  assign wr_addr = RegDst ? rd : rt;
  assign wb_data = MemtoReg ? Data_in : alu_res;

  // Next-PC selection; jump outranks a taken branch
  assign pc4       = pc_reg + 32'd4;
  assign pc_branch = pc4 + {ext[29:0], 2'b00};
  assign pc_jump   = {pc4[31:28], target, 2'b00};

  always_comb begin
    pc_next = pc4;
    if (Jump) begin
      pc_next = pc_jump;
    end else if (Branch && zero) begin
      pc_next = pc_branch;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= '0;
    end else begin
      pc_reg <= pc_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (RegWrite && (wr_addr != 5'd0)) begin
      regs[wr_addr] <= wb_data;
    end
  end

  assign PC_out   = pc_reg;
  assign ALU_out  = alu_res;
  assign Data_out = rt_data;

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: expected values are queued when a step is
// driven and popped when the matching DUT output is sampled.
module tb_data_path;

  logic        clk = 1'b0;
  logic        rst;
  logic        Jump;
  logic        Branch;
  logic [2:0]  ALU_Control;
  logic        ALUSrc_B;
  logic        RegWrite;
  logic        RegDst;
  logic        MemtoReg;
  logic [25:0] inst_field;
  logic [31:0] Data_in;
  logic [31:0] PC_out;
  logic [31:0] ALU_out;
  logic [31:0] Data_out;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  data_path dut (
    .clk         (clk),
    .rst         (rst),
    .Jump        (Jump),
    .Branch      (Branch),
    .ALU_Control (ALU_Control),
    .ALUSrc_B    (ALUSrc_B),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .inst_field  (inst_field),
    .Data_in     (Data_in),
    .PC_out      (PC_out),
    .ALU_out     (ALU_out),
    .Data_out    (Data_out)
  );

  function automatic logic [25:0] mk(input logic [4:0] rs_f, input logic [4:0] rt_f,
                                     input logic [15:0] imm_f);
    return {rs_f, rt_f, imm_f};
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input logic j, input logic b, input logic [2:0] op, input logic srcb,
                     input logic rw, input logic rdst, input logic m2r, input logic [25:0] inst);
    Jump        = j;
    Branch      = b;
    ALU_Control = op;
    ALUSrc_B    = srcb;
    RegWrite    = rw;
    RegDst      = rdst;
    MemtoReg    = m2r;
    inst_field  = inst;
  endtask

  // Observes a register through the rt read port with writes disabled
  task automatic read_reg(input string tag, input logic [4:0] r, input logic [31:0] v);
    ctl(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, mk(5'd0, r, 16'd0));
    push(tag, v);
    #1;
    pop_check(Data_out);
  endtask

  task automatic alu_chk(input string tag, input logic [2:0] op, input logic srcb,
                         input logic [25:0] inst, input logic [31:0] v);
    ctl(1'b0, 1'b0, op, srcb, 1'b0, 1'b0, 1'b0, inst);
    push(tag, v);
    #1;
    pop_check(ALU_out);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout checks=%0d", n_checks);
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    rst     = 1'b1;
    Data_in = '0;
    ctl(1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 26'd0);
    #2;
    push("reset_pc", 32'h0);
    pop_check(PC_out);
    read_reg("reset_r8", 5'd8, 32'h0);

    // Jump straight out of reset
    @(negedge clk);
    rst = 1'b0;
    ctl(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 26'h113B7E0);
    push("jump_pc", 32'h044EDF80);
    edge_step();
    pop_check(PC_out);

    // ORI r8 = r0 | 0x4000; old value visible before the edge
    ctl(1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 26'h0084000);
    push("ori_alu", 32'h00004000);
    push("ori_old_r8", 32'h0);
    #1;
    pop_check(ALU_out);
    pop_check(Data_out);
    push("ori_pc", 32'h044EDF84);
    edge_step();
    pop_check(PC_out);
    read_reg("ori_r8", 5'd8, 32'h00004000);

    // ADDI r9 = r8 + 0x800
    ctl(1'b0, 1'b0, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 26'h1090800);
    push("addi_alu", 32'h00004800);
    #1;
    pop_check(ALU_out);
    push("addi_pc", 32'h044EDF88);
    edge_step();
    pop_check(PC_out);
    read_reg("addi_r9", 5'd9, 32'h00004800);

    // SUB r10 = r9 - r8 through the rd write port
    ctl(1'b0, 1'b0, 3'b110, 1'b0, 1'b1, 1'b1, 1'b0, 26'h1285022);
    push("sub_alu", 32'h00000800);
    push("sub_dout", 32'h00004000);
    #1;
    pop_check(ALU_out);
    pop_check(Data_out);
    push("sub_pc", 32'h044EDF8C);
    edge_step();
    pop_check(PC_out);
    read_reg("sub_r10", 5'd10, 32'h00000800);

    // Load write-back into r8
    Data_in = 32'h55AAAA55;
    ctl(1'b0, 1'b0, 3'b110, 1'b1, 1'b1, 1'b0, 1'b1, 26'h1285022);
    push("load_alu", 32'hFFFFF7DE);
    #1;
    pop_check(ALU_out);
    push("load_pc", 32'h044EDF90);
    edge_step();
    pop_check(PC_out);
    read_reg("load_r8", 5'd8, 32'h55AAAA55);

    // Taken branch with backward offset, SLT result 0
    ctl(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 26'h1088000);
    push("br_alu_zero", 32'h0);
    #1;
    pop_check(ALU_out);
    push("br_pc", 32'h044CDF94);
    edge_step();
    pop_check(PC_out);
    read_reg("br_r8_kept", 5'd8, 32'h55AAAA55);
    read_reg("br_r9_kept", 5'd9, 32'h00004800);

    // Remaining ALU functions, r8 = 0x55AAAA55, r9 = 0x4800
    @(negedge clk);
    alu_chk("alu_and", 3'b000, 1'b0, mk(5'd8, 5'd9, 16'd0), 32'h00000800);
    alu_chk("alu_or",  3'b001, 1'b0, mk(5'd8, 5'd9, 16'd0), 32'h55AAEA55);
    alu_chk("alu_xor", 3'b011, 1'b0, mk(5'd8, 5'd9, 16'd0), 32'h55AAE255);
    alu_chk("alu_nor", 3'b100, 1'b0, mk(5'd8, 5'd9, 16'd0), 32'hAA5515AA);
    @(negedge clk);
    alu_chk("alu_srl",      3'b101, 1'b1, mk(5'd8, 5'd0, 16'h0004), 32'h055AAAA5);
    alu_chk("alu_srl_mask", 3'b101, 1'b1, mk(5'd8, 5'd0, 16'h0024), 32'h055AAAA5);
    alu_chk("alu_slt_pos",  3'b111, 1'b1, mk(5'd0, 5'd0, 16'h0001), 32'h00000001);
    alu_chk("alu_add_neg",  3'b010, 1'b1, mk(5'd8, 5'd0, 16'hFFFF), 32'h55AAAA54);

    // r11 = 0 - 1
    @(negedge clk);
    ctl(1'b0, 1'b0, 3'b110, 1'b1, 1'b1, 1'b0, 1'b0, mk(5'd0, 5'd11, 16'h0001));
    push("sub_neg_alu", 32'hFFFFFFFF);
    #1;
    pop_check(ALU_out);
    edge_step();
    read_reg("r11", 5'd11, 32'hFFFFFFFF);
    @(negedge clk);
    alu_chk("alu_slt_signed", 3'b111, 1'b1, mk(5'd11, 5'd0, 16'h0000), 32'h00000001);
    alu_chk("alu_add_wrap",   3'b010, 1'b1, mk(5'd11, 5'd0, 16'h0001), 32'h00000000);

    // Jump outranks a simultaneously taken branch
    ctl(1'b1, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, mk(5'd11, 5'd0, 16'h0001));
    push("jump_prio", 32'h05800004);
    edge_step();
    pop_check(PC_out);

    // Writes to r0 are discarded
    ctl(1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, mk(5'd8, 5'd0, 16'h1234));
    edge_step();
    read_reg("r0_write", 5'd0, 32'h0);

    // Reset asserted between edges clears state at once and blocks write-back
    Data_in = 32'hDEADBEEF;
    ctl(1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b1, mk(5'd0, 5'd12, 16'h0000));
    #1;
    rst = 1'b1;
    #1;
    push("rst_async_pc", 32'h0);
    pop_check(PC_out);
    read_reg("rst_async_r8", 5'd8, 32'h0);
    ctl(1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b1, mk(5'd0, 5'd12, 16'h0000));
    edge_step();
    push("rst_hold_pc", 32'h0);
    pop_check(PC_out);
    read_reg("rst_no_wb_r12", 5'd12, 32'h0);

    // First edge after release: branch back to 0xFFFFFFFC, then wrap to 0
    @(negedge clk);
    rst = 1'b0;
    ctl(1'b0, 1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, mk(5'd0, 5'd0, 16'hFFFE));
    edge_step();
    push("pc_wrap_hi", 32'hFFFFFFFC);
    pop_check(PC_out);
    Data_in = 32'hCAFEF00D;
    ctl(1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1, mk(5'd0, 5'd12, 16'h0000));
    edge_step();
    push("pc_wrap_zero", 32'h0);
    pop_check(PC_out);
    read_reg("post_rst_r12", 5'd12, 32'hCAFEF00D);

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
